// File: rtl/ula_result_serializer_pkg.sv
// ============================================================================
// Module  : ula_pkg
// Purpose : Shared types for the ULA result serializer (result word, byte index).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ula_pkg;

    localparam int ULA_RESULT_W = 16;

    typedef struct packed {
        logic                    zero;
        logic [ULA_RESULT_W-1:0] result;
    } ula_result_t;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } ula_byte_idx_e;

    // B2 carries the zero flag; it is only reached when the flag byte is enabled.
    function automatic logic [7:0] select_byte(input ula_result_t   word,
                                               input ula_byte_idx_e idx,
                                               input logic          lsb_first);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = word.result[7:0];
        hi = word.result[15:8];
        case (idx)
            B0:      return lsb_first ? lo : hi;
            B1:      return lsb_first ? hi : lo;
            default: return {7'b0, word.zero};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ula_result_serializer_if.sv
// ============================================================================
// Module  : ula_result_serializer_if
// Purpose : Word-in / byte-out handshake bundle of the ULA result serializer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ula_result_serializer_if
    import ula_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [ULA_RESULT_W-1:0]  in_result;
    logic                     in_zero;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_byte;
    logic                     out_first;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output in_valid,
        input  in_ready,
        output in_result,
        output in_zero,
        input  out_valid,
        output out_ready,
        input  out_byte,
        input  out_first,
        input  out_last,
        input  level
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_result,
        input  in_zero,
        output out_valid,
        input  out_ready,
        output out_byte,
        output out_first,
        output out_last,
        output level
    );

endinterface

`default_nettype wire

// File: rtl/ula_result_serializer_fifo.sv
// ============================================================================
// Module  : ula_result_fifo
// Purpose : Synchronous FIFO of ula_result_t words with occupancy count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ula_result_fifo
    import ula_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire ula_result_t            i_data,
    input  wire logic                   i_pop,
    output ula_result_t                 o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_level
);

    localparam int                 C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]      C_FULL = (C_AW + 1)'(DEPTH);

    ula_result_t        r_mem [DEPTH];
    logic [C_AW-1:0]    r_wr_ptr;
    logic [C_AW-1:0]    r_rd_ptr;
    logic [C_AW:0]      r_level;

    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_level == C_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/ula_result_serializer.sv
// ============================================================================
// Module  : ula_result_serializer
// Purpose : Buffers 16-bit ULA results and emits them as byte sequences.
//           Define ULA_SER_FLAG_BYTE_EN to append a zero-flag byte per word.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ula_result_serializer
    import ula_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    ula_result_serializer_if.slave      bus
);

`ifdef ULA_SER_FLAG_BYTE_EN
    localparam ula_byte_idx_e C_LAST_IDX = B2;
`else
    localparam ula_byte_idx_e C_LAST_IDX = B1;
`endif

    ula_byte_idx_e              r_idx;

    ula_result_t                w_in_word;
    ula_result_t                w_head;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(DEPTH):0]     w_level;
    logic                       w_out_valid;
    logic                       w_in_ready;
    logic                       w_push;
    logic                       w_fire;
    logic                       w_is_last;
    logic                       w_pop;

    assign w_in_word.zero   = bus.in_zero;
    assign w_in_word.result = bus.in_result;

    // in_ready depends only on occupancy and reset, never on out_ready.
    assign w_in_ready  = !rst && !w_full;
    assign w_out_valid = !w_empty;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_fire      = w_out_valid && bus.out_ready;
    assign w_is_last   = (r_idx == C_LAST_IDX);
    assign w_pop       = w_fire && w_is_last;

    ula_result_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in_word),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= B0;
        end else if (w_fire) begin
            if (w_is_last) begin
                r_idx <= B0;
            end else begin
                case (r_idx)
                    B0:      r_idx <= B1;
                    B1:      r_idx <= B2;
                    default: r_idx <= B0;
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    // Gate with out_valid so the unreset FIFO storage never shows up on out_byte.
    assign bus.out_byte  = w_out_valid ? select_byte(w_head, r_idx, LSB_FIRST) : 8'h00;
    assign bus.out_first = (r_idx == B0);
    assign bus.out_last  = w_is_last;
    assign bus.level     = w_level;

endmodule

`default_nettype wire
